// File: rtl/chn_sched_pkg.sv
// Shared types and default sizing for the channel scheduler.
package chn_sched_pkg;

  localparam int NUM_CHN     = 8;
  localparam int CHN_W       = 3;
  localparam int TIMEOUT_CNT = 450;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

endpackage

// File: rtl/chn_sched_rr_arb.sv
// Round-robin pick of the first request after the last granted channel.
module rr_arb #(
  parameter int NUM_CHN = chn_sched_pkg::NUM_CHN,
  parameter int CHN_W   = chn_sched_pkg::CHN_W
) (
  input  logic [NUM_CHN-1:0] req,
  input  logic [CHN_W-1:0]   last,
  output logic [CHN_W-1:0]   gnt_idx,
  output logic               gnt_vld
);
  import chn_sched_pkg::*;

  // Walk from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int off = NUM_CHN; off >= 1; off--) begin
      if (req[last + CHN_W'(off)]) begin
        gnt_idx = last + CHN_W'(off);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chn_sched.sv
// Shares one ADPCM datapath among NUM_CHN channels, round-robin.
// Define CHN_SCHED_TIMEOUT_EN to abandon a service when fa_done never arrives.
module chn_sched #(
  parameter int NUM_CHN     = chn_sched_pkg::NUM_CHN,
  parameter int CHN_W       = chn_sched_pkg::CHN_W,
  parameter int TIMEOUT_CNT = chn_sched_pkg::TIMEOUT_CNT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CHN-1:0] chn_req,
  input  logic               fs,
  input  logic               fa_done,
  output logic               fa_trig,
  output logic [CHN_W-1:0]   chn_sel,
  output logic               wr_en,
  output logic [CHN_W-1:0]   wr_addr,
  output logic               busy,
  output logic               error
);
  import chn_sched_pkg::*;

  if (NUM_CHN != (1 << CHN_W) || TIMEOUT_CNT < 2) begin : g_bad_cfg
    $error("chn_sched: NUM_CHN must equal 2**CHN_W and TIMEOUT_CNT must be >= 2");
  end

  state_t               state, state_nxt;
  logic [NUM_CHN-1:0]   pending;
  logic [NUM_CHN-1:0]   sel_onehot;
  logic [NUM_CHN-1:0]   pend_clr;
  logic [NUM_CHN-1:0]   overrun;
  logic [CHN_W-1:0]     last_grant;
  logic [CHN_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 to_hit;
  logic                 svc_end;

  rr_arb #(
    .NUM_CHN (NUM_CHN),
    .CHN_W   (CHN_W)
  ) u_arb (
    .req     (pending),
    .last    (last_grant),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

`ifdef CHN_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CNT + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == START) begin
      to_cnt <= '0;
    end else if (state == WAIT && to_cnt != TO_W'(TIMEOUT_CNT)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires on the edge that completes the TIMEOUT_CNT-th WAIT cycle; fa_done wins a tie.
  assign to_hit = (state == WAIT) && !fa_done && (to_cnt >= TO_W'(TIMEOUT_CNT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_vld) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (fa_done) state_nxt = WB;
               else if (to_hit) state_nxt = IDLE;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fa_trig = (state == START);
    wr_en   = (state == WB);
    busy    = (state != IDLE);
  end

  assign wr_addr    = chn_sel;
  assign sel_onehot = NUM_CHN'(1) << chn_sel;
  assign svc_end    = (state == WB) || to_hit;
  assign pend_clr   = svc_end ? sel_onehot : '0;
  // The channel being served may re-request without it counting as an overrun.
  assign overrun    = chn_req & pending & ~(busy ? sel_onehot : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      last_grant <= CHN_W'(NUM_CHN - 1);
      chn_sel    <= '0;
      error      <= 1'b0;
    end else begin
      pending <= (pending & ~pend_clr) | chn_req;
      if (state == IDLE && gnt_vld) chn_sel <= gnt_idx;
      if (svc_end) last_grant <= chn_sel;
      if ((|overrun) || (fs && (|pending)) || to_hit) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chn_sched.sv
// Randomized and directed bench for chn_sched against a cycle-level reference model.
module tb_chn_sched;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int TO = 20;

  logic         clk, reset, fs, fa_done;
  logic [N-1:0] chn_req;
  logic         fa_trig, wr_en, busy, error;
  logic [W-1:0] chn_sel, wr_addr;

  chn_sched #(.NUM_CHN(N), .CHN_W(W), .TIMEOUT_CNT(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .chn_req (chn_req),
    .fs      (fs),
    .fa_done (fa_done),
    .fa_trig (fa_trig),
    .chn_sel (chn_sel),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .busy    (busy),
    .error   (error)
  );

  always #5 clk = ~clk;

  int n_chk, n_pass;

  // Reference model: m_step 0 = free, 1 = trigger cycle, 2 = waiting on datapath, 3 = write cycle.
  bit [N-1:0] m_pend;
  int         m_last, m_sel, m_step, m_wcnt;
  bit         m_err;

  int resp_cnt, done_dly, wr_cnt;
  bit hold_done;
  int wr_hist[N];
  int grants[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int rr_pick(input bit [N-1:0] p, input int last);
    for (int off = 1; off <= N; off++) begin
      int k;
      k = (last + off) % N;
      if (p[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_last = N - 1; m_sel = 0; m_step = 0; m_wcnt = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit [N-1:0] clr;
    int nstep;
    if (reset) begin
      model_reset();
      return;
    end
    clr = '0;
    nstep = m_step;
    for (int k = 0; k < N; k++)
      if (chn_req[k] && m_pend[k] && !(m_step != 0 && m_sel == k)) m_err = 1;
    if (fs && m_pend != 0) m_err = 1;
    case (m_step)
      0: if (m_pend != 0) begin m_sel = rr_pick(m_pend, m_last); nstep = 1; end
      1: begin nstep = 2; m_wcnt = 0; end
      2: if (fa_done) nstep = 3;
         else begin
           m_wcnt++;
`ifdef CHN_SCHED_TIMEOUT_EN
           if (m_wcnt == TO) begin m_err = 1; clr[m_sel] = 1; m_last = m_sel; nstep = 0; end
`endif
         end
      default: begin clr[m_sel] = 1; m_last = m_sel; nstep = 0; end
    endcase
    m_pend = (m_pend & ~clr) | chn_req;
    m_step = nstep;
  endtask

  task automatic clear_logs();
    wr_cnt = 0; resp_cnt = 0; grants.delete();
    for (int k = 0; k < N; k++) wr_hist[k] = 0;
  endtask

  // One clock: model updates on the edge, outputs checked on the falling edge, pulses dropped.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("fa_trig", fa_trig, 32'(m_step == 1));
    chk("wr_en",   wr_en,   32'(m_step == 3));
    chk("busy",    busy,    32'(m_step != 0));
    chk("chn_sel", chn_sel, m_sel);
    chk("wr_addr", wr_addr, m_sel);
    chk("error",   error,   m_err);
    chk("pending", dut.pending, m_pend);
    if (fa_trig) grants.push_back(int'(chn_sel));
    if (wr_en) begin wr_cnt++; wr_hist[wr_addr]++; end
    chn_req = '0; fs = 0; fa_done = 0;
    if (m_step == 1) resp_cnt = done_dly;
    else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0 && !hold_done) fa_done = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    clear_logs();
  endtask

  task automatic reset_async();
    #2 reset = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_trig", fa_trig, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_sel", chn_sel, 0);
    chk("arst_err", error, 0);
    model_reset();
    cyc(); cyc();
    reset = 0;
    clear_logs();
  endtask

  initial begin
    clk = 0; reset = 1; chn_req = '0; fs = 0; fa_done = 0;
    hold_done = 0; done_dly = 3; n_chk = 0; n_pass = 0;
    model_reset(); clear_logs();

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_last", dut.last_grant, N - 1);

    // Single request, slow datapath
    done_dly = 10;
    chn_req = 8'h01; cyc(); cyc();
    chk("s1_trig", fa_trig, 1);
    chk("s1_sel", chn_sel, 0);
    repeat (15) cyc();
    chk("s1_wr_cnt", wr_cnt, 1);
    chk("s1_wr_addr0", wr_hist[0], 1);
    chk("s1_err", error, 0);

    // All channels at once
    do_reset(); done_dly = 1;
    chn_req = 8'hFF;
    repeat (60) cyc();
    chk("s2_ngrant", grants.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("s2_order", (i < grants.size()) ? grants[i] : 32'hFF, i);
    chk("s2_wr_cnt", wr_cnt, 8);
    chk("s2_pend", dut.pending, 0);

    // Wrap-around after last grant 5
    do_reset(); done_dly = 2;
    chn_req = 8'h20; repeat (12) cyc();
    grants.delete();
    chn_req = 8'h21; repeat (20) cyc();
    chk("s3_ngrant", grants.size(), 2);
    chk("s3_first", (grants.size() > 0) ? grants[0] : 32'hFF, 0);
    chk("s3_second", (grants.size() > 1) ? grants[1] : 32'hFF, 5);

    // Overrun on a waiting channel
    do_reset(); done_dly = 8;
    chn_req = 8'h01; cyc();
    chn_req = 8'h08; cyc();
    chk("s4_err_before", error, 0);
    chn_req = 8'h08; cyc();
    chk("s4_err", error, 1);
    repeat (40) cyc();
    chk("s4_wr3", wr_hist[3], 1);
    chk("s4_wr_total", wr_cnt, 2);

    // Frame slip with channel 2 pending
    do_reset(); done_dly = 3;
    chn_req = 8'h04; cyc();
    fs = 1; cyc();
    chk("s5_err", error, 1);
    repeat (20) cyc();
    chk("s5_wr2", wr_hist[2], 1);
    chk("s5_gnt", (grants.size() > 0) ? grants[0] : 32'hFF, 2);

    // Datapath never answers
    do_reset(); hold_done = 1;
    chn_req = 8'h02;
`ifdef CHN_SCHED_TIMEOUT_EN
    repeat (40) cyc();
    chk("s6_wr_cnt", wr_cnt, 0);
    chk("s6_err", error, 1);
    chk("s6_busy", busy, 0);
    chk("s6_last", dut.last_grant, 1);
`else
    repeat (100) cyc();
    chk("s6_busy", busy, 1);
    chk("s6_wr_cnt", wr_cnt, 0);
    hold_done = 0;
    fa_done = 1;
    repeat (5) cyc();
    chk("s6_wr_late", wr_cnt, 1);
    chk("s6_err", error, 0);
`endif
    hold_done = 0;

    // Reset in the middle of a service
    do_reset(); done_dly = 10;
    chn_req = 8'h10; repeat (4) cyc();
    chk("s7_busy", busy, 1);
    reset_async();
    done_dly = 2;
    chn_req = 8'hFF; repeat (8) cyc();
    chk("s7_first", (grants.size() > 0) ? grants[0] : 32'hFF, 0);
    chk("s7_no_wr4", wr_hist[4], 0);

    // Random traffic, no overruns or slips
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      done_dly = $urandom_range(1, 12);
      if ($urandom % 4 == 0) begin
        int k;
        k = $urandom % N;
        if (!m_pend[k]) chn_req[k] = 1;
      end
      if (m_step != 2 && $urandom % 32 == 0) fa_done = 1;
      cyc();
    end
    chk("r1_err", error, 0);

    // Random traffic including overruns and frame slips
    do_reset();
    for (int c = 0; c < 600; c++) begin
      done_dly = $urandom_range(1, 12);
      if ($urandom % 3 == 0) chn_req = N'($urandom & $urandom);
      if ($urandom % 20 == 0) fs = 1;
      if (m_step != 2 && $urandom % 32 == 0) fa_done = 1;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
